// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues word fetches, buffers returned
// words with their PCs and hands them to decode over a valid/ready handshake.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_X = (CW+1)'(BUF_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   rsp_pc_reg, rsp_pc_next;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] drop_cnt_reg, drop_cnt_next;
  logic [CW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] fifo_count;

  logic [31:0] pc_mem    [BUF_DEPTH];
  logic [31:0] instr_mem [BUF_DEPTH];

  logic credit, req_fire, push, pop, fifo_empty, fifo_full;

  assign fifo_count = wr_ptr_reg - rd_ptr_reg;
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == DEPTH_C);

  // Credit reserves a buffer slot for every in-flight request, so a response
  // always has somewhere to land even though it cannot be back-pressured.
  assign credit = ({1'b0, outstanding_reg} + {1'b0, fifo_count}) < DEPTH_X;

  assign imem_req_valid = !rst && credit && !redirect_valid;
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign push = imem_resp_valid && (drop_cnt_reg == '0) && !redirect_valid;
  assign pop  = id_valid && id_ready;

  assign id_valid = !fifo_empty;
  assign id_instr = fifo_empty ? 32'h0000_0013 : instr_mem[rd_ptr_reg[AW-1:0]];
  assign id_pc    = fifo_empty ? 32'h0000_0000 : pc_mem[rd_ptr_reg[AW-1:0]];

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    rsp_pc_next      = rsp_pc_reg;
    drop_cnt_next    = drop_cnt_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_resp_valid);
    if (redirect_valid) begin
      // Everything still in flight belongs to the wrong path.
      fetch_pc_next = redirect_pc;
      rsp_pc_next   = redirect_pc;
      drop_cnt_next = outstanding_next;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
    end else begin
      if (req_fire)
        fetch_pc_next = fetch_pc_reg + 32'd4;
      if (imem_resp_valid && (drop_cnt_reg != '0))
        drop_cnt_next = drop_cnt_reg - CW'(1);
      if (push) begin
        rsp_pc_next = rsp_pc_reg + 32'd4;
        wr_ptr_next = wr_ptr_reg + CW'(1);
      end
      if (pop)
        rd_ptr_next = rd_ptr_reg + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      rsp_pc_reg      <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      rsp_pc_reg      <= rsp_pc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg[AW-1:0]]    <= rsp_pc_reg;
      instr_mem[wr_ptr_reg[AW-1:0]] <= imem_resp_data;
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule
